// File: rtl/gsau_writeback_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gsau_writeback_unit: buffers GSAU results and writes them to the vector RF
// in arrival order, with flush/drain control.   Revision: 1.0
// ---------------------------------------------------------------------------
module gsau_writeback_unit #(
  parameter  int VEGGIEREGS = 256,
  parameter  int DATA_W     = 256,
  parameter  int DEPTH      = 4,
  localparam int ADDR_W     = $clog2(VEGGIEREGS),
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_wbdst,
  input  logic [DATA_W-1:0] wb_psum,
  output logic              wb_output_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_wgnt,
  output logic              sb_done,
  output logic [ADDR_W-1:0] sb_done_reg,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_dst_mem  [DEPTH];
  logic [DATA_W-1:0]  r_psum_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_sb_done;
  logic [ADDR_W-1:0]  r_sb_done_reg;
  logic               r_flush_done;
  logic               w_enq;
  logic               w_deq;

  assign wb_output_ready = (r_state == ST_RUN) && (r_count < CNT_W'(DEPTH));
  assign rf_wen          = (r_count != '0);
  assign rf_waddr        = r_dst_mem[r_rd_ptr];
  assign rf_wdata        = r_psum_mem[r_rd_ptr];
  assign w_enq           = wb_valid && wb_output_ready;
  assign w_deq           = rf_wen && rf_wgnt;
  assign sb_done         = r_sb_done;
  assign sb_done_reg     = r_sb_done_reg;
  assign flush_done      = r_flush_done;
  assign occupancy       = r_count;

  // Payload storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_dst_mem[r_wr_ptr]  <= wb_wbdst;
      r_psum_mem[r_wr_ptr] <= wb_psum;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sb_done     <= 1'b0;
      r_sb_done_reg <= '0;
    end else begin
      r_sb_done <= w_deq;
      if (w_deq) r_sb_done_reg <= rf_waddr;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);
    end
  end

  // An empty buffer cannot dequeue, so count == 0 alone ends the drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (flush_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_count == '0 && !w_deq) w_state_nxt = ST_DONE;
      ST_DONE:  if (!flush_req) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gsau_writeback_unit.sv
`default_nettype none
// Testbench for gsau_writeback_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_gsau_writeback_unit;

  localparam int AW = 8;
  localparam int DW = 256;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_wbdst = '0;
  logic [DW-1:0] wb_psum = '0;
  logic          wb_output_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_wgnt = 1'b0;
  logic          sb_done;
  logic [AW-1:0] sb_done_reg;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic [2:0]    occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  gsau_writeback_unit #(.VEGGIEREGS(256), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .wb_valid(wb_valid), .wb_wbdst(wb_wbdst),
    .wb_psum(wb_psum), .wb_output_ready(wb_output_ready), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wgnt(rf_wgnt),
    .sb_done(sb_done), .sb_done_reg(sb_done_reg), .flush_req(flush_req),
    .flush_done(flush_done), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] d);
    return {32{d}};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v; logic [AW-1:0] d; logic g; logic f;
    logic rdy; logic wen; logic [AW-1:0] wa; logic [2:0] occ;
    logic sbd; logic [AW-1:0] sbr; logic fd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [AW-1:0] d, logic g, logic f, logic rdy,
                              logic wen, logic [AW-1:0] wa, logic [2:0] occ,
                              logic sbd, logic [AW-1:0] sbr, logic fd);
    vec_t t;
    t.v = v; t.d = d; t.g = g; t.f = f; t.rdy = rdy; t.wen = wen; t.wa = wa;
    t.occ = occ; t.sbd = sbd; t.sbr = sbr; t.fd = fd;
    return t;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [AW-1:0] dst; logic [DW-1:0] psum; } ent_t;
  ent_t          mq[$];
  int            m_mode;    // 0 accepting, 1 draining, 2 drained
  logic          m_sbd;
  logic [AW-1:0] m_sbr;
  logic          m_fd;

  task automatic model_reset();
    mq.delete(); m_mode = 0; m_sbd = 0; m_sbr = '0; m_fd = 0;
  endtask

  function automatic logic m_ready();
    return (m_mode == 0) && (mq.size() < DEPTH);
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".ready"}, wb_output_ready, m_ready());
    chk({tag, ".wen"}, rf_wen, mq.size() != 0);
    chk({tag, ".occ"}, occupancy, mq.size());
    if (mq.size() != 0) begin
      chk({tag, ".waddr"}, rf_waddr, mq[0].dst);
      chk({tag, ".wdata"}, rf_wdata, mq[0].psum);
    end
    chk({tag, ".sbd"}, sb_done, m_sbd);
    chk({tag, ".sbr"}, sb_done_reg, m_sbr);
    chk({tag, ".fd"}, flush_done, m_fd);
  endtask

  task automatic model_step();
    logic enq, deq, was_empty;
    ent_t e;
    enq = wb_valid && m_ready();
    deq = (mq.size() != 0) && rf_wgnt;
    was_empty = (mq.size() == 0);
    m_sbd = deq;
    if (deq) begin m_sbr = mq[0].dst; void'(mq.pop_front()); end
    if (enq) begin e.dst = wb_wbdst; e.psum = wb_psum; mq.push_back(e); end
    m_fd = 0;
    case (m_mode)
      0: if (flush_req) m_mode = 1;
      1: if (was_empty) begin m_mode = 2; m_fd = 1; end
      default: if (!flush_req) m_mode = 0;
    endcase
  endtask

  task automatic do_reset();
    nRST = 0; wb_valid = 0; rf_wgnt = 0; flush_req = 0;
    model_reset();
    @(posedge CLK); @(negedge CLK);
    model_check("in_reset");
    nRST = 1;
    #1 model_check("post_reset");
  endtask

  task automatic cyc(input string tag);
    #1 model_check(tag);
    model_step();
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] d, input logic g, input logic f);
    wb_valid = v; wb_wbdst = d; wb_psum = pat(d); rf_wgnt = g; flush_req = f;
  endtask

  initial begin
    @(negedge CLK);
    do_reset();

    // Backpressure, in-order release, then flush with 3 entries and empty flush.
    tbl.push_back(mk(1,8'h01,0,0, 1,0,8'h00,0, 0,8'h00,0));
    tbl.push_back(mk(1,8'h02,0,0, 1,1,8'h01,1, 0,8'h00,0));
    tbl.push_back(mk(1,8'h03,0,0, 1,1,8'h01,2, 0,8'h00,0));
    tbl.push_back(mk(1,8'h04,0,0, 1,1,8'h01,3, 0,8'h00,0));
    tbl.push_back(mk(1,8'h05,0,0, 0,1,8'h01,4, 0,8'h00,0));
    tbl.push_back(mk(0,8'h00,1,0, 0,1,8'h01,4, 0,8'h00,0));
    tbl.push_back(mk(0,8'h00,1,0, 1,1,8'h02,3, 1,8'h01,0));
    tbl.push_back(mk(0,8'h00,1,0, 1,1,8'h03,2, 1,8'h02,0));
    tbl.push_back(mk(0,8'h00,1,0, 1,1,8'h04,1, 1,8'h03,0));
    tbl.push_back(mk(0,8'h00,0,0, 1,0,8'h00,0, 1,8'h04,0));
    tbl.push_back(mk(0,8'h00,0,0, 1,0,8'h00,0, 0,8'h04,0));
    tbl.push_back(mk(1,8'h10,0,0, 1,0,8'h00,0, 0,8'h04,0));
    tbl.push_back(mk(1,8'h11,0,0, 1,1,8'h10,1, 0,8'h04,0));
    tbl.push_back(mk(1,8'h12,0,1, 1,1,8'h10,2, 0,8'h04,0));
    tbl.push_back(mk(1,8'h13,1,1, 0,1,8'h10,3, 0,8'h04,0));
    tbl.push_back(mk(0,8'h00,1,1, 0,1,8'h11,2, 1,8'h10,0));
    tbl.push_back(mk(0,8'h00,1,1, 0,1,8'h12,1, 1,8'h11,0));
    tbl.push_back(mk(0,8'h00,1,1, 0,0,8'h00,0, 1,8'h12,0));
    tbl.push_back(mk(0,8'h00,0,1, 0,0,8'h00,0, 0,8'h12,1));
    tbl.push_back(mk(0,8'h00,0,1, 0,0,8'h00,0, 0,8'h12,0));
    tbl.push_back(mk(0,8'h00,0,0, 0,0,8'h00,0, 0,8'h12,0));
    tbl.push_back(mk(0,8'h00,0,0, 1,0,8'h00,0, 0,8'h12,0));
    tbl.push_back(mk(0,8'h00,0,1, 1,0,8'h00,0, 0,8'h12,0));
    tbl.push_back(mk(0,8'h00,0,1, 0,0,8'h00,0, 0,8'h12,0));
    tbl.push_back(mk(0,8'h00,0,0, 0,0,8'h00,0, 0,8'h12,1));
    tbl.push_back(mk(0,8'h00,0,0, 1,0,8'h00,0, 0,8'h12,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].g, tbl[i].f);
      #1;
      chk($sformatf("vec%0d.ready", i), wb_output_ready, tbl[i].rdy);
      chk($sformatf("vec%0d.wen", i), rf_wen, tbl[i].wen);
      chk($sformatf("vec%0d.occ", i), occupancy, tbl[i].occ);
      if (tbl[i].wen) begin
        chk($sformatf("vec%0d.waddr", i), rf_waddr, tbl[i].wa);
        chk($sformatf("vec%0d.wdata", i), rf_wdata, pat(tbl[i].wa));
      end
      chk($sformatf("vec%0d.sbd", i), sb_done, tbl[i].sbd);
      chk($sformatf("vec%0d.sbr", i), sb_done_reg, tbl[i].sbr);
      chk($sformatf("vec%0d.fd", i), flush_done, tbl[i].fd);
      @(posedge CLK); @(negedge CLK);
    end

    // Single result with immediate grant.
    do_reset();
    drive(1, 8'h05, 1, 0);           cyc("single0");
    drive(0, 8'h00, 1, 0);           cyc("single1");
    chk("single.sbd", sb_done, 1'b1);
    chk("single.sbr", sb_done_reg, 8'h05);
    cyc("single2");

    // Sustained push/pop at occupancy 2; pointers wrap several times.
    do_reset();
    drive(1, 8'h20, 0, 0);           cyc("pp_fill0");
    drive(1, 8'h21, 0, 0);           cyc("pp_fill1");
    for (int k = 0; k < 6; k++) begin
      drive(1, 8'h22 + 8'(k), 1, 0);
      #1 chk($sformatf("pp%0d.occ", k), occupancy, 3'd2);
      chk($sformatf("pp%0d.waddr", k), rf_waddr, 8'h20 + 8'(k));
      cyc($sformatf("pp%0d", k));
    end

    // Reset mid-drain abandons the flush.
    do_reset();
    drive(1, 8'h30, 0, 0);           cyc("rd0");
    drive(1, 8'h31, 0, 0);           cyc("rd1");
    drive(1, 8'h32, 0, 1);           cyc("rd2");
    drive(0, 8'h00, 1, 1);           cyc("rd3");
    #3 nRST = 0;
    model_reset();
    #1 chk("rd.occ", occupancy, 3'd0);
    chk("rd.wen", rf_wen, 1'b0);
    chk("rd.ready", wb_output_ready, 1'b1);
    chk("rd.fd", flush_done, 1'b0);
    @(posedge CLK); @(negedge CLK);
    drive(0, 8'h00, 0, 0);
    nRST = 1;
    for (int k = 0; k < 4; k++) cyc($sformatf("rd_after%0d", k));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      wb_valid = ($urandom_range(0, 99) < 60);
      wb_wbdst = AW'($urandom);
      wb_psum  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rf_wgnt  = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 39) == 0) flush_req = ~flush_req;
      #1 model_check("rand");
      model_step();
      @(posedge CLK); @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gsau_writeback_unit.md
GSAU_WRITEBACK_UNIT -- requirements
Module: gsau_writeback_unit

Interface
REQ-001 SHALL provide parameters, one per line as name, default, meaning:
- VEGGIEREGS, 256, vector register count; ADDR_W = $clog2(VEGGIEREGS).
- DATA_W, 256, partial-sum row width in bits.
- DEPTH, 4, result buffer entries (power of two, >= 2).
REQ-002 SHALL provide ports, one per line as name, direction, width, meaning:
- CLK, in, 1, clock.
- nRST, in, 1, reset, asynchronous, active-low.
- wb_valid, in, 1, GSAU result valid.
- wb_wbdst, in, ADDR_W, destination vector register of the result.
- wb_psum, in, DATA_W, result data.
- wb_output_ready, out, 1, unit can accept a result this cycle.
- rf_wen, out, 1, register-file write request.
- rf_waddr, out, ADDR_W, write address.
- rf_wdata, out, DATA_W, write data.
- rf_wgnt, in, 1, register-file write port granted this cycle.
- sb_done, out, 1, one-cycle completion pulse to scoreboard.
- sb_done_reg, out, ADDR_W, register completed by sb_done.
- flush_req, in, 1, level request to drain and stop accepting.
- flush_done, out, 1, one-cycle pulse when drain completes.
- occupancy, out, $clog2(DEPTH)+1, valid buffer entries.

Function
REQ-003 SHALL hold results in a DEPTH-entry circular FIFO of {dst, psum}, with read pointer, write pointer and count.
REQ-004 SHALL enqueue exactly when wb_valid && wb_output_ready, at the rising clock edge.
REQ-005 SHALL drive wb_output_ready = (state == RUN) && (count < DEPTH), combinationally from registers only.
REQ-006 SHALL drive rf_wen = (count != 0), with rf_waddr/rf_wdata taken from the head entry; the head SHALL stay stable until accepted.
REQ-007 SHALL dequeue exactly when rf_wen && rf_wgnt.
REQ-008 SHALL, on simultaneous enqueue and dequeue, hold count unchanged and advance both pointers.
REQ-009 SHALL wrap pointers modulo DEPTH; a full buffer SHALL deassert wb_output_ready, with no overwrite.
REQ-010 SHALL register sb_done = 1 and sb_done_reg = dequeued dst in the cycle after a dequeue; otherwise sb_done = 0 and sb_done_reg holds its value.
REQ-011 SHALL deliver results in arrival order, with no drop or duplication.
REQ-012 SHALL implement the FSM RUN, DRAIN, DONE:
- RUN -> DRAIN when flush_req = 1.
- DRAIN -> DONE when count == 0 and no dequeue is pending this cycle.
- DONE -> RUN when flush_req = 0; otherwise stay in DONE.
REQ-013 SHALL keep wb_output_ready = 0 in DRAIN and DONE, while continuing to dequeue in DRAIN.
REQ-014 SHALL pulse flush_done for exactly one cycle, on the DRAIN -> DONE transition edge (registered).
REQ-015 SHALL, when flush_req is asserted with an empty buffer, reach DONE in the second cycle and pulse flush_done once.
REQ-016 SHALL drive occupancy = count.

Reset
REQ-017 SHALL, on nRST low, asynchronously clear pointers, count, sb_done, sb_done_reg, flush_done and buffer valid state, and set state RUN; buffered results are discarded.
REQ-018 SHALL, while in reset and after release, produce rf_wen = 0, occupancy = 0 and wb_output_ready = 1.
REQ-019 SHALL, on reset mid-drain, abandon the flush and produce no flush_done pulse.

Verification
REQ-020 Single result: wb_wbdst = 0x05, psum = A, rf_wgnt = 1 -> rf_wen with addr 0x05 next cycle, then sb_done = 1 with sb_done_reg = 0x05 one cycle later.
REQ-021 Backpressure: rf_wgnt = 0, push 4 results (dst 1..4) -> occupancy = 4 and wb_output_ready = 0; 5th wb_valid is not accepted; raise rf_wgnt -> writes 1, 2, 3, 4 in order.
REQ-022 Simultaneous push/pop at occupancy 2 for 6 cycles -> occupancy stays 2; pointers wrap; order preserved.
REQ-023 Flush with 3 entries, rf_wgnt = 1 -> ready = 0 from the next cycle, 3 writes, then a single flush_done pulse; ready returns to 1 only after flush_req drops.
REQ-024 nRST asserted with 3 entries mid-drain -> occupancy = 0, rf_wen = 0, no flush_done, state RUN.
